// File: rtl/uart_pkg.sv
// uart_pkg: shared word types, baud_ctrl state encoding and the divisor register map.
package uart_pkg;
    localparam int DL_W  = 16;
    localparam int PSD_W = 4;

    typedef logic [DL_W-1:0]  DL_word_t;
    typedef logic [PSD_W-1:0] PSD_word_t;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PENDING = 2'd1;
    localparam logic [1:0] S_COMMIT  = 2'd2;
    localparam logic [1:0] S_RESTART = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = S_IDLE,
        ST_PENDING = S_PENDING,
        ST_COMMIT  = S_COMMIT,
        ST_RESTART = S_RESTART
    } baud_ctrl_state_t;

    localparam logic [1:0] ADDR_DLL = 2'd0;
    localparam logic [1:0] ADDR_DLM = 2'd1;
    localparam logic [1:0] ADDR_PSD = 2'd2;
    localparam logic [1:0] ADDR_RSV = 2'd3;
endpackage

// File: rtl/baud_ctrl.sv
// baud_ctrl: shadows DLAB-gated DLL/DLM/PSD writes, commits them atomically and sequences the baud_gen restart.
// Define BAUD_CTRL_DEFER_EN to hold the commit until neither TX nor RX has a frame in flight.
module baud_ctrl
    import uart_pkg::*;
#(
    parameter int DL_WIDTH        = DL_W,
    parameter int PSD_WIDTH       = PSD_W,
    parameter int RESTART_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [1:0]           wr_addr,
    input  logic [7:0]           wr_data,
    input  logic                 dlab,
    input  logic                 tx_req,
    input  logic                 rx_req,
    input  logic                 tx_busy,
    input  logic                 rx_busy,
    input  logic                 bg_active,
    output logic [DL_WIDTH-1:0]  divisor_latch,
    output logic [PSD_WIDTH-1:0] psd,
    output logic                 new_baud,
    output logic                 enable_baud,
    output logic                 enable_sample,
    output logic                 cfg_busy,
    output logic                 restart_err
);
`ifdef BAUD_CTRL_DEFER_EN
    localparam bit DEFER = 1'b1;
`else
    localparam bit DEFER = 1'b0;
`endif
    localparam int            TW    = $clog2(RESTART_TIMEOUT + 1);
    localparam logic [TW-1:0] T_MAX = TW'(RESTART_TIMEOUT);

    baud_ctrl_state_t     state, state_nx;
    logic [DL_WIDTH-1:0]  sh_dl;
    logic [PSD_WIDTH-1:0] sh_psd;
    logic [TW-1:0]        timer;
    logic                 dirty, seen_low, wr_ok, busy, commit, timeout, ticking;

    assign wr_ok    = wr_en && dlab && wr_addr != ADDR_RSV;
    assign busy     = tx_busy || rx_busy;
    assign commit   = state_nx == ST_COMMIT;
    assign timeout  = state == ST_RESTART && timer == T_MAX;
    assign ticking  = state_nx != ST_COMMIT && state_nx != ST_RESTART;
    assign cfg_busy = state != ST_IDLE || dirty;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    state_nx = !dirty ? ST_IDLE : (DEFER && busy) ? ST_PENDING : ST_COMMIT;
            ST_PENDING: state_nx = busy ? ST_PENDING : ST_COMMIT;
            ST_COMMIT:  state_nx = ST_RESTART;
            ST_RESTART: state_nx = ((seen_low && bg_active) || timeout) ? ST_IDLE : ST_RESTART;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Outputs load on entry to COMMIT so divisor/psd are already valid while new_baud is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            sh_dl         <= '0;
            sh_psd        <= '0;
            dirty         <= 1'b0;
            divisor_latch <= '0;
            psd           <= '0;
            new_baud      <= 1'b0;
            enable_baud   <= 1'b0;
            enable_sample <= 1'b0;
            restart_err   <= 1'b0;
            timer         <= '0;
            seen_low      <= 1'b0;
        end else begin
            state <= state_nx;
            if (wr_ok && wr_addr == ADDR_DLL) sh_dl[7:0] <= wr_data;
            if (wr_ok && wr_addr == ADDR_DLM) sh_dl[DL_WIDTH-1:8] <= (DL_WIDTH-8)'(wr_data);
            if (wr_ok && wr_addr == ADDR_PSD) sh_psd <= wr_data[PSD_WIDTH-1:0];
            dirty <= wr_ok || (dirty && !commit);
            if (commit) begin
                divisor_latch <= sh_dl;
                psd           <= sh_psd;
            end
            new_baud      <= commit;
            enable_baud   <= tx_req && ticking;
            enable_sample <= rx_req && ticking;
            restart_err   <= timeout ? 1'b1 : wr_ok ? 1'b0 : restart_err;
            timer         <= state != ST_RESTART ? '0 : timer == T_MAX ? timer : timer + 1'b1;
            seen_low      <= state == ST_RESTART && (seen_low || !bg_active);
        end
    end
endmodule

// File: tb/tb_baud_ctrl.sv
// tb_baud_ctrl: directed sequence with random data; committed values are checked against a shadow-register model.
module tb_baud_ctrl;
    import uart_pkg::*;
    localparam int TO = 64;

    logic       clk = 0, reset_n = 0, wr_en = 0, dlab = 0;
    logic       tx_req = 0, rx_req = 0, tx_busy = 0, rx_busy = 0, bg_active;
    logic [1:0] wr_addr = 0;
    logic [7:0] wr_data = 0;
    DL_word_t   divisor_latch;
    PSD_word_t  psd;
    logic       new_baud, enable_baud, enable_sample, cfg_busy, restart_err;
    int         n_pass = 0, n_tot = 0;

    always #5 clk = ~clk;

    baud_ctrl #(.DL_WIDTH(16), .PSD_WIDTH(4), .RESTART_TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dlab(dlab), .tx_req(tx_req), .rx_req(rx_req), .tx_busy(tx_busy), .rx_busy(rx_busy),
        .bg_active(bg_active), .divisor_latch(divisor_latch), .psd(psd), .new_baud(new_baud),
        .enable_baud(enable_baud), .enable_sample(enable_sample), .cfg_busy(cfg_busy),
        .restart_err(restart_err)
    );

    // baud_gen stand-in: inactive for three cycles after each new_baud unless held active
    int   bg_cnt = 0;
    logic bg_stuck = 0;
    assign bg_active = bg_stuck || bg_cnt == 0;
    always @(posedge clk) bg_cnt <= new_baud ? 3 : bg_cnt > 0 ? bg_cnt - 1 : 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Model: register contents as written; a commit must carry what was written before its rising edge.
    logic [15:0] m_dl = 0, s_dl = 0;
    logic [3:0]  m_psd = 0, s_psd = 0;
    logic        prev_nb = 0;
    int          pulses = 0;
    logic [15:0] pulse_dl[$];

    always @(posedge clk) begin
        s_dl  <= m_dl;
        s_psd <= m_psd;
    end

    always @(negedge clk) begin
        if (new_baud) begin
            pulses++;
            pulse_dl.push_back(divisor_latch);
            check("commit_dl", divisor_latch, s_dl);
            check("commit_psd", psd, s_psd);
            check("commit_gates", {enable_baud, enable_sample}, 0);
            check("pulse_width", prev_nb, 0);
        end
        prev_nb <= new_baud;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        tick(1);
        wr_en = 0;
        if (dlab && a == ADDR_DLL) m_dl[7:0] = d;
        if (dlab && a == ADDR_DLM) m_dl[15:8] = d;
        if (dlab && a == ADDR_PSD) m_psd = d[3:0];
    endtask

    task automatic wait_pulses(input int target, input int budget, input string tag);
        int t = 0;
        while (pulses < target && t < budget) begin
            tick(1);
            t++;
        end
        check(tag, pulses, target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0, n;
        logic [31:0] rd;
        logic [7:0]  d;
        tick(3);
        check("rst_dl", divisor_latch, 0);
        check("rst_psd", psd, 0);
        check("rst_new_baud", new_baud, 0);
        check("rst_err", restart_err, 0);
        check("rst_busy", cfg_busy, 0);
        check("rst_en", {enable_baud, enable_sample}, 0);
        reset_n = 1; tx_req = 1; rx_req = 1;
        tick(2);
        check("idle_en", {enable_baud, enable_sample}, 2'b11);

        // back-to-back writes: DLL commits at once, DLM/PSD land on and after it and fold into one follow-up
        dlab = 1;
        wr(ADDR_DLL, 8'h8B);
        wr(ADDR_DLM, 8'h02);
        wr(ADDR_PSD, 8'h00);
        wait_pulses(2, 40, "b2b_pulses");
        tick(8);
        check("b2b_first", pulse_dl[0], 16'h008B);
        check("b2b_dl_651", divisor_latch, 651);
        check("b2b_psd", psd, 0);
        check("b2b_no_extra", pulses, 2);
        check("b2b_idle", cfg_busy, 0);

        dlab = 0;
        wr(ADDR_DLL, 8'h36);
        check("nodlab_busy", cfg_busy, 0);
        tick(6);
        check("nodlab_pulses", pulses, 2);
        check("nodlab_dl", divisor_latch, 16'h028B);
        dlab = 1;
        wr(ADDR_RSV, 8'($urandom));
        check("rsv_busy", cfg_busy, 0);
        tick(4);
        check("rsv_pulses", pulses, 2);

        tx_busy = 1;
        wr(ADDR_DLL, 8'd54);
`ifdef BAUD_CTRL_DEFER_EN
        tick(10);
        check("defer_hold", pulses, 2);
        check("defer_busy", cfg_busy, 1);
        check("defer_en", enable_baud, 1);
        tx_busy = 0;
        wait_pulses(3, 4, "defer_release");
`else
        wait_pulses(3, 4, "nodefer_commit");
`endif
        tx_busy = 0;
        tick(8);
        check("defer_dl", divisor_latch, 16'h0236);

        // exact latency, then a DLM write landing on the COMMIT cycle
        d = 8'($urandom);
        p0 = pulses;
        wr(ADDR_DLL, d);
        check("lat_not_early", new_baud, 0);
        tick(1);
        check("lat_pulse", new_baud, 1);
        wr(ADDR_DLM, 8'h01);
        wait_pulses(p0 + 2, 40, "cw_pulses");
        check("cw_first_old", pulse_dl[p0], {8'h02, d});
        check("cw_second_new", pulse_dl[p0 + 1], {8'h01, d});
        tick(8);

        // restart timeout, with writes during RESTART coalescing into one commit
        bg_stuck = 1;
        p0 = pulses;
        wr(ADDR_PSD, 8'($urandom_range(15)));
        wait_pulses(p0 + 1, 4, "to_pulse");
        tick(2);
        check("to_gated", {enable_baud, enable_sample}, 0);
        check("to_busy", cfg_busy, 1);
        rd = $urandom;
        wr(ADDR_DLL, rd[7:0]);
        wr(ADDR_DLM, rd[15:8]);
        wr(ADDR_PSD, {4'h0, rd[19:16]});
        check("to_no_commit", pulses, p0 + 1);
        n = 5;
        while (!restart_err && n < 200) begin
            tick(1);
            n++;
        end
        check("to_window", n >= TO - 1 && n <= TO + 3, 1);
        check("to_en_restore", {enable_baud, enable_sample}, 2'b11);
        bg_stuck = 0;
        wait_pulses(p0 + 2, 6, "coal_pulse");
        tick(8);
        check("coal_single", pulses, p0 + 2);
        check("coal_dl", divisor_latch, rd[15:0]);
        check("coal_psd", psd, rd[19:16]);
        check("err_sticky", restart_err, 1);
        wr(ADDR_PSD, 8'h03);
        check("err_clear", restart_err, 0);
        tick(12);

        // reset mid-sequence discards the pending shadow
        p0 = pulses;
        wr(ADDR_DLL, 8'($urandom));
        wr(ADDR_DLM, 8'($urandom));
        tick(1);
        reset_n = 0;
        m_dl = 0; m_psd = 0;
        tick(1);
        check("mid_rst_dl", divisor_latch, 0);
        check("mid_rst_psd", psd, 0);
        check("mid_rst_busy", cfg_busy, 0);
        check("mid_rst_nb", new_baud, 0);
        reset_n = 1;
        tick(10);
        check("mid_rst_discard", pulses, p0 + 1);
        check("mid_rst_dl_hold", divisor_latch, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
